matrix_scan_driver: RTL and testbench
=====================================

// Module: matrix_scan_driver
// PURPOSE
//  Downstream display stage for the 5x7 LED matrix. Takes a full 5-row x 7-column frame from
//  the pattern/shift-register stage over a valid/ready handshake and double-buffers it.
//  Scans the active frame one column at a time, driving the column strobes and row data pins.
//  Frames swap only at frame boundaries, so the display never shows a torn frame.
// PARAMETERS
//  CLK_PER_COL  1000  clk cycles each column stays lit (>=1)
//  CNT_W        16    prescaler width; must hold CLK_PER_COL-1
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst             in   1   asynchronous, active-high reset
//  frame_in        in   35  frame pixels; bit r*7+c = row r (0..4), column c (0..6); 1 = lit
//  frame_valid     in   1   frame_in valid
//  frame_ready     out  1   shadow buffer empty, frame can be accepted
//  scan_en         in   1   1 = scanning, 0 = display blanked, scan frozen
//  acender_coluna  out  7   column strobes, active-low one-hot (bit c low = column c lit)
//  saida_linha     out  5   row data for the lit column, active-high
//  frame_done      out  1   1-cycle pulse at every column 6 -> 0 wrap
// BEHAVIOUR
//  - Reset (async): presc=0, col=0, active=0, shadow=0, pending=0, frame_ready=1,
//    acender_coluna=7'h7F, saida_linha=5'h00, frame_done=0. Reset mid-scan drops any pending frame.
//  - Prescaler: while scan_en=1, counts 0..CLK_PER_COL-1 then wraps. tick = scan_en & presc==CLK_PER_COL-1.
//    While scan_en=0: presc forced to 0, col held.
//  - Column counter: on tick, col <= col+1; col==6 wraps to 0. Wrap cycle = end of frame.
//  - Handshake: frame_ready = ~pending (registered). Accept = frame_valid & frame_ready
//    -> shadow <= frame_in, pending <= 1. frame_valid while ready=0 is ignored; source holds data.
//  - Swap: on tick with col==6 and pending=1 -> active <= shadow, pending <= 0, ready=1 next cycle.
//    Accept and swap can never share a cycle (accept needs pending=0, swap needs pending=1).
//    An accept in the wrap cycle is shown from the following frame boundary, not this one.
//  - frame_done: registered, 1 in the cycle after each wrap tick, whether or not a swap occurred.
//  - Outputs registered, one cycle of latency from col/active/scan_en:
//    scan_en=1 -> acender_coluna <= ~(7'b1<<col), saida_linha[r] <= active[r*7+col].
//    scan_en=0 -> acender_coluna <= 7'h7F, saida_linha <= 0.
//    Re-enabling resumes at the held column with a full CLK_PER_COL period.
//  - CLK_PER_COL=1: tick every enabled cycle; a column advances each clk.
//  - Exactly one acender_coluna bit is low whenever scanning. Never more than one.
// CONFIGURATION
//  GHOST_BLANK_EN defined: in the cycle after each cycle with presc==0 (the first cycle of every
//    column period), outputs are blanked (7'h7F, 5'h00). Each column is lit CLK_PER_COL-1
//    cycles, which removes row/column switching ghosting. Requires CLK_PER_COL>=2.
//  GHOST_BLANK_EN undefined: no blanking; each column is lit all CLK_PER_COL cycles.
// TESTING (CLK_PER_COL=4 unless noted)
//  1 Assert rst then release -> acender_coluna=7'h7F, saida_linha=0, frame_ready=1, frame_done=0.
//  2 Load 35'h7_FFFF_FFFF, scan_en=1 -> blank/old frame until first wrap, then strobes
//    7E,7D,7B,77,6F,5F,3F (4 cycles each), saida_linha=5'h1F, frame_done every 28 cycles.
//  3 Load frame A, then hold frame_valid with B -> frame_ready=0 and B rejected until A swaps at
//    wrap. B is accepted the cycle after ready=1 and displayed one frame later.
//  4 Load col-3-only frame (bits 3,10,17,24,31). Drop scan_en while col=3 -> next cycle 7F/00.
//    Raise after 10 cycles -> 77/1F for 4 cycles, then 6F/00.
//  5 Assert rst asynchronously mid-column 5 with a frame pending -> outputs 7F/00 immediately.
//    After release, col=0, ready=1, old pending frame never displayed.
//  6 GHOST_BLANK_EN, CLK_PER_COL=4 -> each strobe low 3 cycles with 1 blank cycle between columns.
//    Without the macro -> 4 cycles, no gap.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// 5x7 LED matrix column scanner with a double-buffered frame input (valid/ready).
// Optional macro GHOST_BLANK_EN blanks the first cycle of every column period.
module matrix_scan_driver #(
  parameter int CLK_PER_COL = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        scan_en,
  output logic [6:0]  acender_coluna,
  output logic [4:0]  saida_linha,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(CLK_PER_COL - 1);
  localparam logic [2:0]       COL_LAST  = 3'd6;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       col_q, col_d;
  logic [34:0]      active_q, active_d;
  logic [34:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [6:0]       strobe_q, strobe_d;
  logic [4:0]       row_q, row_d;
  logic             done_q, done_d;

  logic tick, wrap, accept, swap, blank;

  // Row bits of one column: pixel (r, c) lives at bit r*7+c.
  function automatic logic [4:0] column_bits(input logic [34:0] frame, input logic [2:0] col);
    logic [4:0] bits;
    bits = '0;
    for (int r = 0; r < 5; r++) begin
      bits[r] = frame[r*7 + int'(col)];
    end
    return bits;
  endfunction

  always_comb begin
    tick   = scan_en && (presc_q == PRESC_MAX);
    wrap   = tick && (col_q == COL_LAST);
    accept = frame_valid && ready_q;
    swap   = wrap && pending_q;

    presc_d = '0;
    if (scan_en && !tick) begin
      presc_d = presc_q + 1'b1;
    end

    col_d = col_q;
    if (tick) begin
      col_d = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
    end

    shadow_d = accept ? frame_in : shadow_q;
    active_d = swap ? shadow_q : active_q;

    // Accept and swap are mutually exclusive: one needs pending low, the other high.
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (swap) begin
      pending_d = 1'b0;
    end
    ready_d = ~pending_d;
    done_d  = wrap;

    blank = ~scan_en;
`ifdef GHOST_BLANK_EN
    if (presc_q == '0) begin
      blank = 1'b1;
    end
`endif
    strobe_d = 7'h7F;
    row_d    = 5'h00;
    if (!blank) begin
      strobe_d = ~(7'b1 << col_q);
      row_d    = column_bits(active_q, col_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      col_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      strobe_q  <= 7'h7F;
      row_q     <= 5'h00;
      done_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      col_q     <= col_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      strobe_q  <= strobe_d;
      row_q     <= row_d;
      done_q    <= done_d;
    end
  end

  assign frame_ready    = ready_q;
  assign acender_coluna = strobe_q;
  assign saida_linha    = row_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver: stimulus pushes expected outputs, a monitor pops them.
// Honours GHOST_BLANK_EN the same way as the design.
module tb_matrix_scan_driver;

  localparam int P = 4;

  typedef struct packed {
    logic [6:0] strobe;
    logic [4:0] rows;
    logic       rdy;
    logic       done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [34:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        scan_en = 1'b0;
  logic [6:0]  acender_coluna;
  logic [4:0]  saida_linha;
  logic        frame_done;

  int checks = 0;
  int passed = 0;

  // Reference model: position within the frame as a count of enabled cycles.
  int          en_cnt = 0;
  logic [34:0] shown = '0;
  logic [34:0] pend_q[$];
  obs_t        exp_q[$];

  localparam logic [34:0] ALL_ON = 35'h7_FFFF_FFFF;
  localparam logic [34:0] COL3   = (35'd1 << 3) | (35'd1 << 10) | (35'd1 << 17) |
                                   (35'd1 << 24) | (35'd1 << 31);
  localparam logic [34:0] FRAME_A = 35'h5_5555_5555;
  localparam logic [34:0] FRAME_B = 35'h2_AAAA_AAAA;

  matrix_scan_driver #(.CLK_PER_COL(P), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_in       (frame_in),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .scan_en        (scan_en),
    .acender_coluna (acender_coluna),
    .saida_linha    (saida_linha),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    en_cnt = 0;
    shown  = '0;
    pend_q.delete();
    exp_q.delete();
  endtask

  // Drive one cycle of inputs and predict the outputs after the coming rising edge.
  task automatic step(input logic en, input logic vld, input logic [34:0] f);
    obs_t e;
    int   col, presc;
    bit   tick, blank, acc;
    @(negedge clk);
    scan_en = en; frame_valid = vld; frame_in = f;
    col   = (en_cnt / P) % 7;
    presc = en_cnt % P;
    tick  = en && (presc == P - 1);
    blank = !en;
`ifdef GHOST_BLANK_EN
    if (presc == 0) blank = 1'b1;
`endif
    e = '0;
    e.strobe = 7'h7F;
    if (!blank) begin
      e.strobe[col] = 1'b0;
      for (int r = 0; r < 5; r++) e.rows[r] = shown[r*7 + col];
    end
    e.done = tick && (col == 6);
    acc = vld && (pend_q.size() == 0);
    if (tick && col == 6 && pend_q.size() > 0) shown = pend_q.pop_front();
    if (acc) pend_q.push_back(f);
    e.rdy = (pend_q.size() == 0);
    if (en) en_cnt = (en_cnt + 1) % (7 * P);
    else    en_cnt = (en_cnt / P) * P;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_strobe"}, 32'(acender_coluna), 32'h7F);
    chk({tag, "_rows"},   32'(saida_linha),    32'h0);
    chk({tag, "_ready"},  32'(frame_ready),    32'h1);
    chk({tag, "_done"},   32'(frame_done),     32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scan_en = 1'b0; frame_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
  endtask

  // Monitor: every cycle with a prediction outstanding is compared.
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {acender_coluna, saida_linha, frame_ready, frame_done};
      checks++;
      if (a === e) passed++;
      else $display("FAIL scan at %0t: got strobe=%h rows=%h rdy=%b done=%b want strobe=%h rows=%h rdy=%b done=%b",
                    $time, a.strobe, a.rows, a.rdy, a.done, e.strobe, e.rows, e.rdy, e.done);
    end
  end

  initial begin
    logic        en_r;
    logic [63:0] rnd;

    do_reset();

    // Full-on frame: shown from the first wrap onward.
    step(1'b1, 1'b1, ALL_ON);
    repeat (70) step(1'b1, 1'b0, '0);

    // A accepted, B held on valid and only taken once A has swapped in.
    step(1'b1, 1'b1, FRAME_A);
    repeat (80) step(1'b1, 1'b1, FRAME_B);

    // Column-3 frame; freeze scanning while column 3 is lit, then resume.
    step(1'b1, 1'b1, COL3);
    for (int k = 0; k < 200; k++) begin
      if (pend_q.size() == 0 && shown == COL3 && (en_cnt / P) % 7 == 3 && en_cnt % P == 1) break;
      step(1'b1, 1'b0, '0);
    end
    repeat (10) step(1'b0, 1'b0, '0);
    repeat (40) step(1'b1, 1'b0, '0);

    // Randomised traffic with occasional scan_en bursts low.
    en_r = 1'b1;
    repeat (900) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      rnd = {$urandom, $urandom};
      step(en_r, ($urandom_range(0, 2) == 0), rnd[34:0]);
    end

    // Asynchronous reset in column 5 with a frame pending.
    do_reset();
    step(1'b1, 1'b1, ALL_ON);
    for (int k = 0; k < 100 && en_cnt < 5 * P + 2; k++) step(1'b1, 1'b0, '0);
    chk("pending_before_reset", 32'(pend_q.size()), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    scan_en = 1'b0; frame_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (70) step(1'b1, 1'b0, '0);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
